// File: rtl/pwm_ramp_pkg.sv
// Shared defaults for the sawtooth PWM generator.
// Holds the ramp width default and the derived terminal count.
package pwm_ramp_pkg;

    localparam int PWM_WIDTH_DEF = 8;

    // Largest value representable in an unsigned field of the given width.
    function automatic int full_scale(input int width);
        return (2 ** width) - 1;
    endfunction

    localparam int PWM_MAX_COUNT_DEF = full_scale(PWM_WIDTH_DEF);

endpackage

// File: rtl/pwm_ramp_counter.sv
// Enabled sawtooth counter 0..MAX_COUNT with a one-cycle wrap pulse.
// Ports: clk, rst (async high), samp_en; ramp (registered count),
// ramp_next/at_max (next-value lookahead for the parent), wrap (registered).
module pwm_ramp_counter
    import pwm_ramp_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH_DEF,
    parameter int MAX_COUNT = full_scale(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             samp_en,
    output logic [WIDTH-1:0] ramp,
    output logic [WIDTH-1:0] ramp_next,
    output logic             at_max,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_COUNT);

    assign at_max    = (ramp == MAX_V);
    assign ramp_next = at_max ? '0 : ramp + WIDTH'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ramp <= '0;
            wrap <= 1'b0;
        end else if (samp_en) begin
            ramp <= ramp_next;
            wrap <= at_max;
        end else begin
            // Count holds between ticks; the pulse never stretches.
            wrap <= 1'b0;
        end
    end

endmodule

// File: rtl/pwm_ramp.sv
// Sawtooth-compare PWM: pwm is high while ramp < ref_sh, where ref_sh is
// ref_val captured at each period start. Ports: clk, rst (async high),
// samp_en, ref_val in; pwm, ramp, wrap out (all registered).
module pwm_ramp
    import pwm_ramp_pkg::*;
#(
    parameter int WIDTH     = PWM_WIDTH_DEF,
    parameter int MAX_COUNT = full_scale(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             samp_en,
    input  logic [WIDTH-1:0] ref_val,
    output logic             pwm,
    output logic [WIDTH-1:0] ramp,
    output logic             wrap
);

    logic [WIDTH-1:0] ramp_next;
    logic             at_max;
    logic [WIDTH-1:0] ref_sh;
    logic [WIDTH-1:0] ref_next;

    pwm_ramp_counter #(
        .WIDTH     (WIDTH),
        .MAX_COUNT (MAX_COUNT)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .samp_en   (samp_en),
        .ramp      (ramp),
        .ramp_next (ramp_next),
        .at_max    (at_max),
        .wrap      (wrap)
    );

    // The wrapping tick must compare against the reference it is about to
    // load, otherwise the first sample of each period would use the old one.
    assign ref_next = at_max ? ref_val : ref_sh;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ref_sh <= '0;
            pwm    <= 1'b0;
        end else if (samp_en) begin
            ref_sh <= ref_next;
            pwm    <= (ramp_next < ref_next);
        end
    end

endmodule

// File: tb/tb_pwm_ramp.sv
// Directed self-checking bench for pwm_ramp (default 8-bit instance
// plus a MAX_COUNT=99 instance).
module tb_pwm_ramp;

    logic       clk = 1'b0;
    logic       rst;
    logic       samp_en;
    logic [7:0] ref_val;
    logic       pwm;
    logic [7:0] ramp;
    logic       wrap;

    logic       rst2;
    logic       en2;
    logic [7:0] ref2;
    logic       pwm2;
    logic [7:0] ramp2;
    logic       wrap2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pwm_ramp dut (
        .clk     (clk),
        .rst     (rst),
        .samp_en (samp_en),
        .ref_val (ref_val),
        .pwm     (pwm),
        .ramp    (ramp),
        .wrap    (wrap)
    );

    pwm_ramp #(.MAX_COUNT(99)) dut99 (
        .clk     (clk),
        .rst     (rst2),
        .samp_en (en2),
        .ref_val (ref2),
        .pwm     (pwm2),
        .ramp    (ramp2),
        .wrap    (wrap2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        samp_en = 1'b0;
        ref_val = 8'h00;
        repeat (3) tick();
        tests++;
        if (ramp !== 8'd0) begin
            fails++;
            $display("FAIL reset_ramp: got %0d want 0", ramp);
        end
        tests++;
        if (pwm !== 1'b0) begin
            fails++;
            $display("FAIL reset_pwm: got %b want 0", pwm);
        end
        tests++;
        if (wrap !== 1'b0) begin
            fails++;
            $display("FAIL reset_wrap: got %b want 0", wrap);
        end
        samp_en = 1'b1;
        repeat (2) tick();
        tests++;
        if (ramp !== 8'd0) begin
            fails++;
            $display("FAIL rst_dominates: got %0d want 0", ramp);
        end
        rst = 1'b0;
    endtask

    task automatic test_first_period();
        int bad = 0;
        ref_val = 8'h0F;
        samp_en = 1'b1;
        for (int k = 1; k <= 255; k++) begin
            tick();
            tests++;
            if (ramp !== 8'(k) || pwm !== 1'b0 || wrap !== 1'b0) begin
                fails++;
                bad++;
                if (bad < 5)
                    $display("FAIL first_period k=%0d: got r=%0d p=%b w=%b want r=%0d p=0 w=0",
                             k, ramp, pwm, wrap, k);
            end
        end
    endtask

    task automatic test_duty();
        int high;
        for (int p = 0; p < 2; p++) begin
            high = 0;
            for (int i = 0; i < 256; i++) begin
                tick();
                if (pwm === 1'b1) high++;
                tests++;
                if (ramp !== 8'(i) || pwm !== (i < 15) || wrap !== (i == 0)) begin
                    fails++;
                    $display("FAIL duty i=%0d: got r=%0d p=%b w=%b want p=%b w=%b",
                             i, ramp, pwm, wrap, (i < 15), (i == 0));
                end
            end
            tests++;
            if (high != 15) begin
                fails++;
                $display("FAIL duty_high: got %0d want 15", high);
            end
        end
    endtask

    task automatic test_samp_en_toggle();
        int high = 0;
        int wraps = 0;
        for (int j = 0; j < 256; j++) begin
            samp_en = 1'b1;
            tick();
            if (pwm === 1'b1) high++;
            if (wrap === 1'b1) wraps++;
            tests++;
            if (ramp !== 8'(j) || pwm !== (j < 15) || wrap !== (j == 0)) begin
                fails++;
                $display("FAIL toggle_on j=%0d: got r=%0d p=%b w=%b", j, ramp, pwm, wrap);
            end
            samp_en = 1'b0;
            tick();
            if (wrap === 1'b1) wraps++;
            tests++;
            if (ramp !== 8'(j) || pwm !== (j < 15) || wrap !== 1'b0) begin
                fails++;
                $display("FAIL toggle_hold j=%0d: got r=%0d p=%b w=%b", j, ramp, pwm, wrap);
            end
        end
        tests++;
        if (high != 15 || wraps != 1) begin
            fails++;
            $display("FAIL toggle_counts: got high=%0d wraps=%0d want 15 1", high, wraps);
        end
        samp_en = 1'b1;
    endtask

    task automatic test_ref_change();
        int high = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            tests++;
            if (ramp !== 8'(i) || pwm !== (i < 15)) begin
                fails++;
                $display("FAIL refchg_cur i=%0d: got r=%0d p=%b want p=%b", i, ramp, pwm, (i < 15));
            end
            if (i == 8'h40) ref_val = 8'h80;
        end
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pwm === 1'b1) high++;
            tests++;
            if (ramp !== 8'(i) || pwm !== (i < 128)) begin
                fails++;
                $display("FAIL refchg_next i=%0d: got r=%0d p=%b want p=%b", i, ramp, pwm, (i < 128));
            end
        end
        tests++;
        if (high != 128) begin
            fails++;
            $display("FAIL refchg_high: got %0d want 128", high);
        end
    endtask

    task automatic test_boundary();
        int high = 0;
        ref_val = 8'h00;
        for (int i = 0; i < 256; i++) begin
            tick();
            tests++;
            if (pwm !== 1'b0) begin
                fails++;
                $display("FAIL ref_zero i=%0d: got %b want 0", i, pwm);
            end
        end
        ref_val = 8'hFF;
        for (int i = 0; i < 256; i++) begin
            tick();
            if (pwm === 1'b1) high++;
            tests++;
            if (pwm !== (i < 255)) begin
                fails++;
                $display("FAIL ref_full i=%0d: got %b want %b", i, pwm, (i < 255));
            end
        end
        tests++;
        if (high != 255) begin
            fails++;
            $display("FAIL ref_full_high: got %0d want 255", high);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i <= 8'h90; i++) tick();
        tests++;
        if (ramp !== 8'h90 || pwm !== 1'b1) begin
            fails++;
            $display("FAIL pre_rst: got r=%0d p=%b want 144 1", ramp, pwm);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (ramp !== 8'd0 || pwm !== 1'b0 || wrap !== 1'b0) begin
            fails++;
            $display("FAIL async_rst: got r=%0d p=%b w=%b want 0 0 0", ramp, pwm, wrap);
        end
        ref_val = 8'h40;
        repeat (2) tick();
        rst = 1'b0;
        for (int k = 1; k <= 255; k++) begin
            tick();
            tests++;
            if (ramp !== 8'(k) || pwm !== 1'b0) begin
                fails++;
                $display("FAIL post_rst k=%0d: got r=%0d p=%b want p=0", k, ramp, pwm);
            end
        end
        tick();
        tests++;
        if (ramp !== 8'd0 || pwm !== 1'b1 || wrap !== 1'b1) begin
            fails++;
            $display("FAIL post_rst_wrap: got r=%0d p=%b w=%b want 0 1 1", ramp, pwm, wrap);
        end
    endtask

    task automatic test_max99();
        int high = 0;
        int maxr = 0;
        ref2 = 8'd50;
        rst2 = 1'b0;
        en2 = 1'b1;
        for (int k = 1; k <= 99; k++) begin
            tick();
            tests++;
            if (ramp2 !== 8'(k) || pwm2 !== 1'b0) begin
                fails++;
                $display("FAIL m99_first k=%0d: got r=%0d p=%b", k, ramp2, pwm2);
            end
        end
        for (int i = 0; i < 100; i++) begin
            tick();
            if (pwm2 === 1'b1) high++;
            if (int'(ramp2) > maxr) maxr = int'(ramp2);
            tests++;
            if (ramp2 !== 8'(i) || pwm2 !== (i < 50) || wrap2 !== (i == 0)) begin
                fails++;
                $display("FAIL m99 i=%0d: got r=%0d p=%b w=%b", i, ramp2, pwm2, wrap2);
            end
        end
        tests++;
        if (high != 50 || maxr != 99) begin
            fails++;
            $display("FAIL m99_counts: got high=%0d max=%0d want 50 99", high, maxr);
        end
        ref2 = 8'd200;
        for (int i = 0; i < 100; i++) begin
            tick();
            tests++;
            if (pwm2 !== 1'b1 || ramp2 !== 8'(i)) begin
                fails++;
                $display("FAIL m99_over i=%0d: got r=%0d p=%b want p=1", i, ramp2, pwm2);
            end
        end
    endtask

    initial begin
        rst2 = 1'b1;
        en2 = 1'b0;
        ref2 = 8'd0;
        test_reset();
        test_first_period();
        test_duty();
        test_samp_en_toggle();
        test_ref_change();
        test_boundary();
        test_async_reset();
        test_max99();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pwm_ramp.md
PWM_RAMP -- requirements
Module: pwm_ramp

Interface
REQ-001 Parameter WIDTH, default 8, sets the bit width of the ramp, reference and comparator.
REQ-002 Parameter MAX_COUNT, default 2**WIDTH-1, is the terminal ramp value; the legal range is 1..2**WIDTH-1.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 samp_en  input  1  sample-tick enable; the ramp SHALL advance only on clk edges where samp_en=1.
REQ-006 ref_val  input  WIDTH  duty reference, unsigned, sampled once per ramp period.
REQ-007 pwm  output  1  registered PWM output.
REQ-008 ramp  output  WIDTH  registered sawtooth counter value.
REQ-009 wrap  output  1  registered pulse marking the start of a new period.

Function
REQ-010 On each enabled tick, ramp SHALL step 0,1,…,MAX_COUNT, then wrap back to 0, giving a period of MAX_COUNT+1 ticks.
REQ-011 With samp_en=0, ramp, pwm, wrap and the shadow reference SHALL hold, except that wrap SHALL be 0.
REQ-012 Internal register ref_sh SHALL load ref_val only on the enabled tick where ramp transitions MAX_COUNT->0; ref_val changes mid-period SHALL NOT affect the current period.
REQ-013 On every enabled tick, pwm SHALL be registered as (ramp_next < ref_next), where:
- ramp_next is the new ramp value;
- ref_next is ref_val if ramp_next wraps to 0, otherwise ref_sh.
REQ-014 As a result, pwm and ramp SHALL be cycle-aligned, with pwm=1 exactly while ramp < ref_sh.
REQ-015 Duty SHALL be ref_sh/(MAX_COUNT+1).
REQ-016 ref_sh=0 SHALL give pwm constantly 0 for the period.
REQ-017 ref_sh > MAX_COUNT SHALL give pwm constantly 1 for the period.
REQ-018 wrap SHALL be 1 for exactly one clk cycle after the enabled tick on which ramp wraps to 0, and 0 otherwise.
REQ-019 All comparisons SHALL be unsigned WIDTH-bit, with no overflow beyond WIDTH bits.
REQ-020 If MAX_COUNT < 2**WIDTH-1, ramp SHALL wrap at MAX_COUNT and SHALL never reach higher values.

Reset
REQ-021 While rst=1, the outputs and internal registers SHALL be held at: ramp=0, ref_sh=0, pwm=0, wrap=0.
REQ-022 rst assertion mid-period SHALL clear immediately (asynchronously).
REQ-023 After reset release, the first period SHALL run with ref_sh=0, so pwm stays 0 until the first wrap loads ref_val.
REQ-024 rst SHALL dominate samp_en.

Structure
REQ-025 Package pwm_ramp_pkg SHALL hold the WIDTH default (8) and the derived MAX_COUNT default constant.
REQ-026 Sub-module pwm_ramp_counter SHALL implement the enabled wrap counter and its wrap pulse.
REQ-027 The top level SHALL hold ref_sh and the pwm comparator register.
REQ-028 The design SHALL contain no latches and no combinational output paths.

Verification
REQ-029 Reset release with ref_val=0x0F and samp_en=1 constant:
- ticks 0..255: ramp counts 0..255 with pwm=0;
- after the wrap: wrap pulses once, pwm=1 for ramp 0..14 (15 ticks) and 0 for ramp 15..255 (241 ticks);
- this pattern repeats every 256 ticks.
REQ-030 samp_en toggling 1,0,1,0: ramp advances every other clk, period 512 clks, duty still 15/256 of enabled ticks, wrap pulses once per period.
REQ-031 ref_val changed from 0x0F to 0x80 when ramp=0x40: current period keeps a 15-tick high time; the next period is high for 128 ticks.
REQ-032 Boundary references:
- ref_val=0x00 gives pwm=0 for the whole period;
- ref_val=0xFF gives pwm high for 255 of 256 ticks (low only at ramp=255).
REQ-033 Assert rst when ramp=0x90: ramp, pwm and wrap go to 0 without waiting for clk; after release, the first period has pwm=0.
REQ-034 With MAX_COUNT=99 and ref_val=50: period is 100 ticks, pwm high 50 ticks, and ramp never exceeds 99.
